// File: rtl/alu_bist_pkg.sv
// Shared constants, types and helpers for the ALU BIST controller.
// Corner-vector table is consumed only when ALU_BIST_CORNER_EN is defined.
package alu_bist_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned N_OPS    = 5;
  localparam int unsigned N_CORNER_VECS = 8;

  localparam logic [SEL_W-1:0] SEL_AND = 3'b000;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SUB = 3'b110;
  localparam logic [SEL_W-1:0] SEL_SLT = 3'b111;

  localparam logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [SEL_W-1:0]  sel;
  } alu_vec_t;

  // Galois step shared by the operand LFSRs and the MISR
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return {s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [SEL_W-1:0] op_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    return SEL_AND;
      3'd1:    return SEL_OR;
      3'd2:    return SEL_ADD;
      3'd3:    return SEL_SUB;
      3'd4:    return SEL_SLT;
      default: return SEL_AND;
    endcase
  endfunction

  function automatic alu_vec_t corner_vec(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{in1: 32'h0000_0000, in2: 32'h0000_0000, sel: SEL_ADD};
      3'd1:    return '{in1: 32'h7FFF_FFFF, in2: 32'h0000_0001, sel: SEL_ADD};
      3'd2:    return '{in1: 32'h8000_0000, in2: 32'h0000_0001, sel: SEL_SUB};
      3'd3:    return '{in1: 32'hFFFF_FFFF, in2: 32'h0000_0001, sel: SEL_ADD};
      3'd4:    return '{in1: 32'h0000_0000, in2: 32'h0000_0001, sel: SEL_SLT};
      3'd5:    return '{in1: 32'h8000_0000, in2: 32'h0000_0000, sel: SEL_SLT};
      3'd6:    return '{in1: 32'hFFFF_FFFF, in2: 32'hFFFF_FFFF, sel: SEL_AND};
      default: return '{in1: 32'h0000_0000, in2: 32'h0000_0000, sel: SEL_OR};
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_controller_lfsr.sv
// 32-bit Galois LFSR; with data_in non-zero it acts as a MISR.
// Synchronous reset is applied by the parent through load/seed.
module bist_lfsr32
  import alu_bist_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] state
);

  logic [DATA_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (load)      r_state <= seed;
    else if (step) r_state <= lfsr_next(r_state) ^ data_in;
  end

  assign state = r_state;

endmodule

// File: rtl/alu_bist_controller.sv
// ALU built-in self-test driver: LFSR operands, op-table select, MISR signature.
// Define ALU_BIST_CORNER_EN to prepend 8 fixed corner vectors to each run.
module alu_bist_controller
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2BAD,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] signature,
  output logic [DATA_W-1:0] ALU_In1,
  output logic [DATA_W-1:0] ALU_In2,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Output,
  input  logic              ALU_Zero_Flag,
  input  logic              ALU_Overflow_Flag
);

`ifdef ALU_BIST_CORNER_EN
  localparam int unsigned N_CORNER = N_CORNER_VECS;
`else
  localparam int unsigned N_CORNER = 0;
`endif
  localparam int unsigned N_TOTAL = NUM_VECTORS + N_CORNER;
  localparam int unsigned KW      = 17;

  localparam logic [DATA_W-1:0] SEED1     = (SEED == '0) ? 32'h1 : SEED;
  localparam logic [DATA_W-1:0] SEED2_RAW = SEED ^ 32'h5A5A_5A5A;
  localparam logic [DATA_W-1:0] SEED2     = (SEED2_RAW == '0) ? 32'h1 : SEED2_RAW;

  state_t            r_state;
  state_t            w_next;
  logic [KW-1:0]     r_k;
  logic [2:0]        r_op_idx;
  logic              w_run;
  logic              w_start_run;
  logic              w_last;
  logic              w_advance;
  logic              w_corner;
  logic              w_load;
  logic [DATA_W-1:0] w_seed1;
  logic [DATA_W-1:0] w_seed2;
  logic [DATA_W-1:0] w_lfsr1;
  logic [DATA_W-1:0] w_lfsr2;
  logic [DATA_W-1:0] w_misr_in;

  assign w_run       = (r_state == ST_RUN);
  assign w_start_run = !reset && start && !w_run;
  assign w_last      = (r_k == KW'(N_TOTAL - 1));
  // Hold on the final vector so operands/select keep their last values in DONE
  assign w_advance   = w_run && !w_last;
  assign w_load      = reset || w_start_run;
  assign w_seed1     = reset ? '0 : SEED1;
  assign w_seed2     = reset ? '0 : SEED2;
  assign w_misr_in   = ALU_Output ^ {30'b0, ALU_Overflow_Flag, ALU_Zero_Flag};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start is ignored while running
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: if (start)  w_next = ST_RUN;
      default:             w_next = ST_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        done = 1'b1;
        pass = (signature == GOLDEN_SIG);
      end
      default: ;
    endcase
  end

  // Vector counter and op-table index (index advances on LFSR vectors only)
  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_k      <= '0;
      r_op_idx <= '0;
    end else if (w_advance) begin
      r_k <= r_k + KW'(1);
      if (!w_corner) r_op_idx <= (r_op_idx == 3'(N_OPS - 1)) ? 3'd0 : r_op_idx + 3'd1;
    end
  end

  bist_lfsr32 u_lfsr_op1 (
    .clk     (clk),
    .load    (w_load),
    .step    (w_advance && !w_corner),
    .seed    (w_seed1),
    .data_in ('0),
    .state   (w_lfsr1)
  );

  bist_lfsr32 u_lfsr_op2 (
    .clk     (clk),
    .load    (w_load),
    .step    (w_advance && !w_corner),
    .seed    (w_seed2),
    .data_in ('0),
    .state   (w_lfsr2)
  );

  bist_lfsr32 u_misr (
    .clk     (clk),
    .load    (w_load),
    .step    (w_run),
    .seed    ('0),
    .data_in (w_misr_in),
    .state   (signature)
  );

`ifdef ALU_BIST_CORNER_EN
  alu_vec_t w_cv;
  assign w_cv     = corner_vec(r_k[2:0]);
  assign w_corner = w_run && (r_k < KW'(N_CORNER));
  assign ALU_In1  = w_corner ? w_cv.in1 : w_lfsr1;
  assign ALU_In2  = w_corner ? w_cv.in2 : w_lfsr2;
  assign ALU_Sel  = w_corner ? w_cv.sel : op_sel(r_op_idx);
`else
  assign w_corner = 1'b0;
  assign ALU_In1  = w_lfsr1;
  assign ALU_In2  = w_lfsr2;
  assign ALU_Sel  = op_sel(r_op_idx);
`endif

endmodule

// File: tb/tb_alu_bist_controller.sv
// Self-checking bench for alu_bist_controller with a behavioural ALU.
// Honours ALU_BIST_CORNER_EN when defined at compile time.
module tb_alu_bist_controller;

`ifdef ALU_BIST_CORNER_EN
  localparam int unsigned NC = 8;
`else
  localparam int unsigned NC = 0;
`endif
  localparam int unsigned NV_A = 4;
  localparam int unsigned NV_B = 16;
  localparam int unsigned NA   = NV_A + NC;
  localparam int unsigned NB   = NV_B + NC;

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h8020_0003 : 32'h0);
  endfunction

  // {result[33:2], overflow[1], zero[0]}
  function automatic logic [33:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    logic [31:0] r;
    logic        ov;
    r  = 32'h0;
    ov = 1'b0;
    case (sel)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b110: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b111: r = {31'b0, ($signed(a) < $signed(b))};
      default: r = 32'h0;
    endcase
    return {r, ov, (r == 32'h0)};
  endfunction

  function automatic logic [2:0] optab(input int unsigned j);
    case (j)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [66:0] corner(input int unsigned k);
    case (k)
      0:       return {32'h0000_0000, 32'h0000_0000, 3'b010};
      1:       return {32'h7FFF_FFFF, 32'h0000_0001, 3'b010};
      2:       return {32'h8000_0000, 32'h0000_0001, 3'b110};
      3:       return {32'hFFFF_FFFF, 32'h0000_0001, 3'b010};
      4:       return {32'h0000_0000, 32'h0000_0001, 3'b111};
      5:       return {32'h8000_0000, 32'h0000_0000, 3'b111};
      6:       return {32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000};
      default: return {32'h0000_0000, 32'h0000_0000, 3'b001};
    endcase
  endfunction

  // Expected vector k as {in1, in2, sel}
  function automatic logic [66:0] vec(input int unsigned k);
    logic [31:0] s1;
    logic [31:0] s2;
    int unsigned j;
`ifdef ALU_BIST_CORNER_EN
    if (k < 8) return corner(k);
`endif
    j  = k - NC;
    s1 = 32'hACE1_2BAD;
    s2 = 32'hF6BB_71F7;
    for (int unsigned i = 0; i < j; i++) begin
      s1 = lstep(s1);
      s2 = lstep(s2);
    end
    return {s1, s2, optab(j % 5)};
  endfunction

  function automatic logic [31:0] model_sig(input int unsigned nv, input logic stuck0);
    logic [31:0] sig;
    logic [66:0] v;
    logic [33:0] r;
    logic [31:0] res;
    sig = 32'h0;
    for (int unsigned k = 0; k < nv + NC; k++) begin
      v   = vec(k);
      r   = alu(v[66:35], v[34:3], v[2:0]);
      res = r[33:2];
      if (stuck0) res[0] = 1'b0;
      sig = lstep(sig) ^ (res ^ {30'b0, r[1:0]});
    end
    return sig;
  endfunction

  localparam logic [31:0] GOLD_A = model_sig(NV_A, 1'b0);

  logic        clk;
  logic        stuck;
  logic        reset_a, start_a, busy_a, done_a, pass_a, zf_a, of_a;
  logic [31:0] sig_a, in1_a, in2_a, out_a;
  logic [2:0]  sel_a;
  logic [33:0] alu_a;
  logic        reset_b, start_b, busy_b, done_b, pass_b, zf_b, of_b;
  logic [31:0] sig_b, in1_b, in2_b, out_b;
  logic [2:0]  sel_b;
  logic [33:0] alu_b;
  int          n_checks;
  int          n_pass;

  assign alu_a = alu(in1_a, in2_a, sel_a);
  assign out_a = {alu_a[33:3], alu_a[2] & ~stuck};
  assign of_a  = alu_a[1];
  assign zf_a  = alu_a[0];
  assign alu_b = alu(in1_b, in2_b, sel_b);
  assign out_b = alu_b[33:2];
  assign of_b  = alu_b[1];
  assign zf_b  = alu_b[0];

  alu_bist_controller #(.NUM_VECTORS(NV_A), .GOLDEN_SIG(GOLD_A)) u_dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .ALU_In1(in1_a), .ALU_In2(in2_a),
    .ALU_Sel(sel_a), .ALU_Output(out_a), .ALU_Zero_Flag(zf_a),
    .ALU_Overflow_Flag(of_a)
  );

  alu_bist_controller #(.NUM_VECTORS(NV_B)) u_dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .ALU_In1(in1_b), .ALU_In2(in2_b),
    .ALU_Sel(sel_b), .ALU_Output(out_b), .ALU_Zero_Flag(zf_b),
    .ALU_Overflow_Flag(of_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One run on DUT A; returns at the sample point of cycle N+1
  task automatic run_a(input logic exp_pass);
    logic [66:0] v;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < int'(NA); k++) begin
      if (k > 0) @(negedge clk);
      v = vec(k);
      check("a_busy", 32'(busy_a), 32'd1);
      check("a_done_low", 32'(done_a), 32'd0);
      check("a_in1", in1_a, v[66:35]);
      check("a_in2", in2_a, v[34:3]);
      check("a_sel", 32'(sel_a), 32'(v[2:0]));
      if (k == 0) check("a_pass_busy", 32'(pass_a), 32'd0);
`ifdef ALU_BIST_CORNER_EN
      if (k == 1) check("a_corner_ovf", 32'(of_a), 32'd1);
`endif
    end
    @(negedge clk);
    v = vec(NA - 1);
    check("a_done", 32'(done_a), 32'd1);
    check("a_busy_low", 32'(busy_a), 32'd0);
    check("a_sig", sig_a, model_sig(NV_A, stuck));
    check("a_pass", 32'(pass_a), 32'(exp_pass));
    check("a_in1_hold", in1_a, v[66:35]);
    check("a_sel_hold", 32'(sel_a), 32'(v[2:0]));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    stuck    = 1'b0;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    start_a  = 1'b1;
    start_b  = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_sig", sig_a, 32'h0);
    check("rst_in1", in1_a, 32'h0);
    check("rst_in2", in2_a, 32'h0);
    check("rst_sel", 32'(sel_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy_a), 32'd0);
    check("idle_done", 32'(done_a), 32'd0);

    run_a(1'b1);
    stuck = 1'b1;
    run_a(1'b0);
    stuck = 1'b0;

    // start held high for a whole run, then immediate restart
    @(negedge clk);
    start_b = 1'b1;
    for (int c = 1; c <= int'(NB); c++) begin
      @(negedge clk);
      check("b_busy", 32'(busy_b), 32'd1);
      check("b_done_low", 32'(done_b), 32'd0);
    end
    @(negedge clk);
    check("b_done", 32'(done_b), 32'd1);
    check("b_busy_low", 32'(busy_b), 32'd0);
    check("b_sig", sig_b, model_sig(NV_B, 1'b0));
    @(negedge clk);
    check("b_restart_busy", 32'(busy_b), 32'd1);
    check("b_restart_done", 32'(done_b), 32'd0);
    check("b_restart_in1", in1_b, vec(0) >> 35);
    start_b = 1'b0;

    // reset in cycle 3 of the restarted run
    @(negedge clk);
    @(negedge clk);
    check("b_c3_busy", 32'(busy_b), 32'd1);
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    check("b_abort_busy", 32'(busy_b), 32'd0);
    check("b_abort_done", 32'(done_b), 32'd0);
    check("b_abort_sig", sig_b, 32'h0);
    check("b_abort_in1", in1_b, 32'h0);
    @(negedge clk);
    check("b_stay_idle", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
